// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit owning the PC, issuing one outstanding imem
// request at a time and buffering returned instructions in a small FIFO.
// Ports: clk/rst (async, active-high); imem_req_* request handshake and
// address; imem_resp_* returned instruction; redirect_* flush and restart;
// inst_valid/inst_ready/inst_pc/inst FIFO head towards the decoder.
module ifu_fetch #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h80000000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(FIFO_DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [XLEN-1:0] fpc_q [FIFO_DEPTH];
  logic [ILEN-1:0] fdat_q [FIFO_DEPTH];
  logic push, pop, stay_wait;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST_C ? '0 : p + 1'b1;
  endfunction
  assign imem_req_valid = state_q == S_REQ;
  assign imem_req_addr = pc_q;
  assign inst_valid = cnt_q != '0;
  assign inst_pc = inst_valid ? fpc_q[rd_q] : '0;
  assign inst = inst_valid ? fdat_q[rd_q] : '0;
  always_comb begin
    push = state_q == S_WAIT && imem_resp_valid && !drop_q && !redirect_valid;
    pop = inst_valid && inst_ready && !redirect_valid;
    // a redirect leaves an accepted request in flight only when its response has not yet returned
    stay_wait = (state_q == S_WAIT && !imem_resp_valid) || (state_q == S_REQ && imem_req_ready);
    state_d = state_q;
    pc_d = pc_q;
    drop_d = drop_q;
    case (state_q)
      S_IDLE: state_d = cnt_q < DEPTH_C ? S_REQ : S_IDLE;
      S_REQ: begin
        state_d = imem_req_ready ? S_WAIT : S_REQ;
        pc_d = imem_req_ready ? pc_q + XLEN'(4) : pc_q;
      end
      S_WAIT: begin
        state_d = !imem_resp_valid ? S_WAIT : (cnt_q + CW'(push) < DEPTH_C ? S_REQ : S_IDLE);
        drop_d = imem_resp_valid ? 1'b0 : drop_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
      state_d = stay_wait ? S_WAIT : S_REQ;
      drop_d = stay_wait;
    end
    cnt_d = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d = redirect_valid ? '0 : (push ? nxt(wr_q) : wr_q);
    rd_d = redirect_valid ? '0 : (pop ? nxt(rd_q) : rd_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // in WAIT without a pending drop, pc_q has already advanced past the request address
  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[wr_q] <= pc_q - XLEN'(4);
      fdat_q[wr_q] <= imem_resp_data;
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized bench for ifu_fetch against a stream-level reference model.
module tb_ifu_fetch;
  localparam logic [63:0] RST_PC = 64'h80000000;
  logic clk = 1'b0;
  logic rst;
  logic imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr, redirect_pc, inst_pc;
  logic [31:0] imem_resp_data, inst;
  logic redirect_valid, inst_valid, inst_ready;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_req, exp_pc, acc_addr, force_pc, a0;
  logic [63:0] pq[$];
  int plat[$];
  int rr, ir, rd, lmin, lmax, ndel, nstart;
  bit force_rd, late, acc;
  always #5 clk = ~clk;
  ifu_fetch #(.XLEN(64), .ILEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst(inst)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'd3) ^ a[63:32] ^ 32'hC0DE0001;
  endfunction
  function automatic logic [63:0] rand_pc();
    return $urandom_range(3) == 0 ? (64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(15))) : {32'h0, $urandom};
  endfunction
  task automatic step();
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    if (late) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = 32'hDEADBEEF;
    end else if (pq.size() > 0) begin
      if (plat[0] == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(pq[0]);
        void'(pq.pop_front());
        void'(plat.pop_front());
      end else plat[0] = plat[0] - 1;
    end
    imem_req_ready = int'($urandom_range(99)) < rr;
    inst_ready = int'($urandom_range(99)) < ir;
    redirect_valid = force_rd || (int'($urandom_range(999)) < rd);
    redirect_pc = force_rd ? force_pc : rand_pc();
    force_rd = 1'b0;
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    if (inst_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", 64'(inst), 64'(mem_word(exp_pc)));
    end else begin
      chk("empty_pc", inst_pc, 64'h0);
      chk("empty_inst", 64'(inst), 64'h0);
    end
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      chk("one_outstanding", 64'(pq.size()), 64'h0);
      acc_addr = imem_req_addr;
      pq.push_back(imem_req_addr);
      plat.push_back(int'($urandom_range(lmax, lmin)));
    end
    if (redirect_valid) begin
      exp_req = redirect_pc & ~64'h3;
      exp_pc = redirect_pc & ~64'h3;
    end else begin
      if (acc) exp_req = exp_req + 64'd4;
      if (inst_valid && inst_ready) begin
        exp_pc = exp_pc + 64'd4;
        ndel++;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    pq.delete();
    plat.delete();
    exp_req = RST_PC;
    exp_pc = RST_PC;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_addr", imem_req_addr, RST_PC);
    chk("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_acc(input string tag);
    for (int i = 0; i < 60; i++) begin
      step();
      if (acc) break;
    end
    chk({tag, "_timeout"}, 64'(acc), 64'h1);
  endtask
  task automatic wait_inst(input string tag);
    for (int i = 0; i < 60; i++) begin
      step();
      if (inst_valid) break;
    end
    chk({tag, "_timeout"}, 64'(inst_valid), 64'h1);
  endtask
  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    force_rd = 1'b0;
    late = 1'b0;
    rd = 0;
    ndel = 0;
    do_reset();
    rr = 100; ir = 0; lmin = 0; lmax = 0;
    repeat (15) step();
    chk("t2_req_idle", 64'(imem_req_valid), 64'h0);
    chk("t2_full", 64'(inst_valid), 64'h1);
    chk("t2_head", inst_pc, RST_PC);
    ir = 100;
    wait_acc("t2_resume");
    chk("t2_resume_addr", acc_addr, 64'h80000008);
    nstart = ndel;
    repeat (20) step();
    chk("t1_rate", 64'(ndel - nstart >= 8), 64'h1);
    lmin = 2; lmax = 2;
    wait_acc("t3_acc");
    force_rd = 1'b1;
    force_pc = 64'h80001002;
    step();
    wait_acc("t3_new");
    chk("t3_addr", acc_addr, 64'h80001000);
    wait_inst("t3_inst");
    chk("t3_first_pc", inst_pc, 64'h80001000);
    rr = 0; lmin = 0; lmax = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (imem_req_valid) break;
    end
    chk("t4_req_timeout", 64'(imem_req_valid), 64'h1);
    a0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        force_rd = 1'b1;
        force_pc = 64'h80002000;
      end
      step();
      chk("t4_valid_held", 64'(imem_req_valid), 64'h1);
      chk("t4_addr", imem_req_addr, i <= 2 ? a0 : 64'h80002000);
    end
    rr = 100; ir = 100;
    wait_inst("t4_inst");
    chk("t4_first_pc", inst_pc, 64'h80002000);
    force_rd = 1'b1;
    force_pc = 64'hFFFFFFFFFFFFFFF8;
    step();
    wait_acc("t5_a");
    chk("t5_a0", acc_addr, 64'hFFFFFFFFFFFFFFF8);
    wait_acc("t5_b");
    chk("t5_a1", acc_addr, 64'hFFFFFFFFFFFFFFFC);
    wait_acc("t5_c");
    chk("t5_a2", acc_addr, 64'h0);
    lmin = 20; lmax = 20;
    wait_acc("t6_acc");
    do_reset();
    rr = 0; lmin = 0; lmax = 0;
    late = 1'b1;
    step();
    late = 1'b0;
    repeat (3) step();
    chk("t6_no_inst", 64'(inst_valid), 64'h0);
    rr = 100;
    wait_acc("t6_first");
    chk("t6_first_addr", acc_addr, RST_PC);
    wait_inst("t6_inst");
    chk("t6_first_pc", inst_pc, RST_PC);
    nstart = ndel;
    for (int k = 0; k < 30; k++) begin
      rr = int'($urandom_range(100, 30));
      ir = int'($urandom_range(100, 20));
      lmin = 0;
      lmax = int'($urandom_range(4));
      rd = int'($urandom_range(40));
      repeat (100) step();
    end
    chk("progress", 64'(ndel - nstart > 100), 64'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
